// File: rtl/input_port_ctrl.sv
// Router input port: buffers single-flit packets, routes the head flit through an
// external XY routing table, requests the chosen output port and forwards on grant.
module input_port_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int NUM_PORTS = 5,
  parameter int ADDR_SZ   = 4,
  parameter int BITS_DIR  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [ADDR_SZ-1:0]   table_addr,
  input  logic [BITS_DIR-1:0]  table_data,
  output logic [NUM_PORTS-1:0] out_req,
  input  logic                 out_gnt,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [PTR_W:0]       occupancy,
  output logic [1:0]           dbg_state
);

  // Handshakes: upstream flit moves when in_valid && in_ready at posedge clk;
  // out_req is held until out_gnt is seen in REQ; out_valid lasts one cycle (SEND).

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_REQ   = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  localparam logic [PTR_W:0]    DEPTH_C     = (PTR_W+1)'(DEPTH);
  localparam logic [BITS_DIR-1:0] NUM_PORTS_C = BITS_DIR'(NUM_PORTS);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W:0]      r_count;
  state_t              r_state;
  state_t              w_next;
  logic [BITS_DIR-1:0] r_dir;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;

  logic                w_in_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_dir_ok;
  logic [DATA_W-1:0]   w_head;
  logic [NUM_PORTS-1:0] w_req;

  assign w_in_ready = (r_count != DEPTH_C);
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_state == S_SEND);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_dir_ok   = (r_dir < NUM_PORTS_C);

  // Storage needs no reset: only entries counted by r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_ROUTE;
      S_ROUTE: w_next = S_REQ;
      // An out-of-range direction never requests, so it can never be granted.
      S_REQ:   if (out_gnt && w_dir_ok) w_next = S_SEND;
      S_SEND:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req = '0;
    if (r_state == S_REQ && w_dir_ok) begin
      w_req[r_dir] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dir       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ROUTE) r_dir <= table_data;
      r_out_valid <= (w_next == S_SEND);
      r_out_data  <= (w_next == S_SEND) ? w_head : '0;
    end
  end

  assign in_ready   = w_in_ready;
  assign table_addr = w_head[ADDR_SZ-1:0];
  assign out_req    = w_req;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign occupancy  = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl in a 2x2 mesh: directed vector table, corner-case
// sequences and random traffic checked against a queue-based port model.
module tb_input_port_ctrl;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int PTR_W     = 2;
  localparam int NUM_PORTS = 5;
  localparam int ADDR_SZ   = 2;
  localparam int BITS_DIR  = 3;

  localparam logic [2:0] D_EAST  = 3'd0;
  localparam logic [2:0] D_WEST  = 3'd1;
  localparam logic [2:0] D_NORTH = 3'd2;
  localparam logic [2:0] D_SOUTH = 3'd3;
  localparam logic [2:0] D_LOCAL = 3'd4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic [ADDR_SZ-1:0]   table_addr;
  logic [BITS_DIR-1:0]  table_data;
  logic [NUM_PORTS-1:0] out_req;
  logic                 out_gnt;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [PTR_W:0]       occupancy;
  logic [1:0]           dbg_state;

  int unsigned node_id;
  int n_checks;
  int n_errors;

  // 2x2 mesh, node id = y*2 + x; X first, then Y; north is decreasing y.
  function automatic logic [2:0] route_xy(input int unsigned id, input logic [1:0] dest);
    int sx, sy, dx, dy;
    sx = int'(id % 2);
    sy = int'(id / 2);
    dx = int'(dest[0]);
    dy = int'(dest[1]);
    if (dx > sx)      return D_EAST;
    else if (dx < sx) return D_WEST;
    else if (dy > sy) return D_SOUTH;
    else if (dy < sy) return D_NORTH;
    else              return D_LOCAL;
  endfunction

  assign table_data = route_xy(node_id, table_addr);

  input_port_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .NUM_PORTS(NUM_PORTS),
    .ADDR_SZ(ADDR_SZ), .BITS_DIR(BITS_DIR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .table_addr(table_addr), .table_data(table_data),
    .out_req(out_req), .out_gnt(out_gnt), .out_valid(out_valid),
    .out_data(out_data), .occupancy(occupancy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic mon_en;
  logic pend_push, pend_pop, pend_rst, prev_ov;
  logic [DATA_W-1:0] pend_data;

  // Model state advances once per edge using flags captured at the previous negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_rst) begin
        exp_q.delete();
      end else begin
        if (pend_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (pend_push) exp_q.push_back(pend_data);
      end
      chk("in_ready", in_ready, exp_q.size() != DEPTH);
      chk("occupancy", occupancy, exp_q.size());
      if (out_req != '0) begin
        if (exp_q.size() == 0) chk("req_empty", out_req, 0);
        else chk("out_req", out_req, 5'(1) << route_xy(node_id, exp_q[0][1:0]));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("ov_empty", out_valid, 0);
        else chk("out_data", out_data, exp_q[0]);
        chk("ov_single_cycle", prev_ov, 0);
      end
      pend_rst  = !rst_n;
      pend_pop  = out_valid;
      pend_push = in_valid && (exp_q.size() < DEPTH);
      pend_data = in_data;
      prev_ov   = out_valid;
    end
  end

  always @(negedge clk) begin
    if (mon_en && dbg_state == 2'd1) begin
      assert (table_data < NUM_PORTS) else $error("routing table returned illegal direction");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_flit(input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (out_req == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (out_req == '0) timeout_fail("wait_req");
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_gnt  = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || dbg_state != 2'd0) timeout_fail("drain");
  endtask

  typedef struct {
    int unsigned       id;
    logic [DATA_W-1:0] data;
    logic [NUM_PORTS-1:0] req;
  } vec_t;

  vec_t vecs[6];

  // Single flit into an empty port with grant high; checks the exact cycle profile.
  task automatic send_one(input vec_t v);
    node_id = v.id;
    out_gnt = 1'b1;
    push_flit(v.data);
    idle_in();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("vec_out_req", out_req, (k == 2) ? v.req : '0);
      chk("vec_out_valid", out_valid, k == 3);
      if (k == 3) chk("vec_out_data", out_data, v.data);
      if (k == 4) chk("vec_occ_after", occupancy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b0;
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    pend_rst  = 1'b0;
    prev_ov   = 1'b0;
    pend_data = '0;
    node_id   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_gnt   = 1'b0;

    vecs[0] = '{id: 0, data: 32'h0000_A003, req: 5'b00001};
    vecs[1] = '{id: 2, data: 32'h0000_B002, req: 5'b10000};
    vecs[2] = '{id: 2, data: 32'h0000_C000, req: 5'b00100};
    vecs[3] = '{id: 3, data: 32'h1234_5672, req: 5'b00010};
    vecs[4] = '{id: 0, data: 32'hFFFF_FFFE, req: 5'b01000};
    vecs[5] = '{id: 1, data: 32'h8000_0001, req: 5'b10000};

    // Reset then idle
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_req", out_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
    end

    // Directed vectors
    for (int i = 0; i < 6; i++) send_one(vecs[i]);

    // Backpressure: fill, drop a fifth flit, then release in order
    node_id = 1;
    out_gnt = 1'b0;
    for (int i = 0; i < 4; i++) push_flit(32'h0000_1000 + 32'(i));
    push_flit(32'hDEAD_BEE0);
    @(negedge clk);
    chk("bp_occ_full", occupancy, 4);
    chk("bp_in_ready", in_ready, 0);
    idle_in();
    @(negedge clk);
    chk("bp_occ_after_drop", occupancy, 4);
    drain();

    // Grant stall: 7 cycles in REQ without grant, grant in cycle 8
    node_id = 0;
    out_gnt = 1'b0;
    push_flit(32'h0000_5503);
    idle_in();
    wait_req();
    for (int i = 0; i < 7; i++) begin
      chk("stall_out_req", out_req, 5'b00001);
      chk("stall_out_valid", out_valid, 0);
      if (i < 6) @(negedge clk);
    end
    @(posedge clk); #1;
    out_gnt = 1'b1;
    @(negedge clk);
    chk("stall_c8_valid", out_valid, 0);
    chk("stall_c8_req", out_req, 5'b00001);
    @(negedge clk);
    chk("stall_grant_valid", out_valid, 1);
    chk("stall_grant_data", out_data, 32'h0000_5503);
    drain();

    // Simultaneous push and pop during SEND at occupancy 2
    node_id = 3;
    out_gnt = 1'b0;
    push_flit(32'h0000_7700);
    push_flit(32'h0000_7701);
    idle_in();
    wait_req();
    @(posedge clk); #1;
    out_gnt = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'h0000_7702;
    @(negedge clk);
    chk("pp_send_valid", out_valid, 1);
    chk("pp_occ_before", occupancy, 2);
    idle_in();
    @(negedge clk);
    chk("pp_occ_after", occupancy, 2);
    drain();

    // Reset while a request is pending with three flits buffered
    node_id = 2;
    out_gnt = 1'b0;
    for (int i = 0; i < 3; i++) push_flit(32'h0000_9900 + 32'(i));
    idle_in();
    wait_req();
    chk("mid_occ", occupancy, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_req", out_req, 0);
    chk("mid_rst_valid", out_valid, 0);
    out_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_rst_no_output", out_valid, 0);
    end

    // Random traffic against the queue model
    for (int seg = 0; seg < 4; seg++) begin
      node_id = $urandom_range(0, 3);
      for (int i = 0; i < 150; i++) begin
        @(posedge clk); #1;
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = $urandom;
        out_gnt  = ($urandom_range(0, 3) != 0);
      end
      drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
